// File: rtl/bit_run_extractor_if.sv
// Word-in / run-out handshake bundle for bit_run_extractor.
// slave is the extractor's view; master is the producer/consumer side.
interface bit_run_extractor_if #(
   parameter int WORD_WIDTH = 8
);
   localparam int INDEX_WIDTH  = $clog2(WORD_WIDTH);
   localparam int LENGTH_WIDTH = $clog2(WORD_WIDTH + 1);

   logic                    input_valid;
   logic                    input_ready;
   logic [WORD_WIDTH-1:0]   input_data;
   logic                    output_valid;
   logic                    output_ready;
   logic [WORD_WIDTH-1:0]   output_mask;
   logic [INDEX_WIDTH-1:0]  output_start;
   logic [LENGTH_WIDTH-1:0] output_length;
   logic                    output_last;
   logic                    output_empty;

   modport slave (
      input  input_valid, input_data, output_ready,
      output input_ready, output_valid, output_mask, output_start,
             output_length, output_last, output_empty
   );

   modport master (
      output input_valid, input_data, output_ready,
      input  input_ready, output_valid, output_mask, output_start,
             output_length, output_last, output_empty
   );
endinterface

// File: rtl/bit_run_extractor.sv
// Splits a captured word into its contiguous runs of set bits, LSB first,
// one registered beat (mask, start, length) per cycle.
//
// state | meaning
// IDLE  | waiting for a word; input_ready high one edge after reset/last beat
// EMIT  | presenting runs of the held word; input ignored
module bit_run_extractor #(
   parameter int WORD_WIDTH   = 8,
   parameter bit RUN_POLARITY = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   bit_run_extractor_if.slave bus
);
   localparam int INDEX_WIDTH  = $clog2(WORD_WIDTH);
   localparam int LENGTH_WIDTH = $clog2(WORD_WIDTH + 1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state;
   logic [WORD_WIDTH-1:0]   rem;

   logic [WORD_WIDTH-1:0]   src;
   logic [WORD_WIDTH-1:0]   lowbit;
   logic [WORD_WIDTH-1:0]   cleared;
   logic [WORD_WIDTH-1:0]   run;
   logic [INDEX_WIDTH-1:0]  start;
   logic [LENGTH_WIDTH-1:0] length;

   // In IDLE the step is evaluated on the incoming word so beat 1 is ready
   // right after the capture edge; in EMIT it works on the held remainder.
   always_comb begin
      src     = (state == IDLE) ? (bus.input_data ^ {WORD_WIDTH{RUN_POLARITY}}) : rem;
      lowbit  = src & (-src);
      cleared = (lowbit + src) & src;
      run     = src ^ cleared;
      start   = '0;
      for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
         if (src[i]) start = INDEX_WIDTH'(i);
      end
      length = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         length = length + LENGTH_WIDTH'(run[i]);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         rem               <= '0;
         bus.input_ready   <= 1'b0;
         bus.output_valid  <= 1'b0;
         bus.output_mask   <= '0;
         bus.output_start  <= '0;
         bus.output_length <= '0;
         bus.output_last   <= 1'b0;
         bus.output_empty  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.input_ready <= 1'b1;
               if (bus.input_valid && bus.input_ready) begin
                  state             <= EMIT;
                  bus.input_ready   <= 1'b0;
                  bus.output_valid  <= 1'b1;
                  bus.output_mask   <= run;
                  bus.output_start  <= start;
                  bus.output_length <= length;
                  bus.output_last   <= (cleared == '0);
                  bus.output_empty  <= (src == '0);
                  rem               <= cleared;
               end
            end
            EMIT: begin
               if (bus.output_valid && bus.output_ready) begin
                  if (bus.output_last) begin
                     state             <= IDLE;
                     bus.input_ready   <= 1'b1;
                     bus.output_valid  <= 1'b0;
                     bus.output_mask   <= '0;
                     bus.output_start  <= '0;
                     bus.output_length <= '0;
                     bus.output_last   <= 1'b0;
                     bus.output_empty  <= 1'b0;
                     rem               <= '0;
                  end else begin
                     bus.output_mask   <= run;
                     bus.output_start  <= start;
                     bus.output_length <= length;
                     bus.output_last   <= (cleared == '0);
                     bus.output_empty  <= 1'b0;
                     rem               <= cleared;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bit_run_extractor.sv
// Directed bench for bit_run_extractor: one polarity-0 and one polarity-1 instance.
module tb_bit_run_extractor;
   logic clock;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   bit_run_extractor_if #(.WORD_WIDTH(8)) a ();
   bit_run_extractor_if #(.WORD_WIDTH(8)) b ();

   bit_run_extractor #(.WORD_WIDTH(8), .RUN_POLARITY(1'b0)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(a.slave));
   bit_run_extractor #(.WORD_WIDTH(8), .RUN_POLARITY(1'b1)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(b.slave));

   always #5 clock = ~clock;

   // {valid, mask[7:0], start[2:0], length[3:0], last, empty}
   function automatic logic [17:0] obs(input bit sel);
      if (sel)
         return {b.output_valid, b.output_mask, b.output_start, b.output_length,
                 b.output_last, b.output_empty};
      return {a.output_valid, a.output_mask, a.output_start, a.output_length,
              a.output_last, a.output_empty};
   endfunction

   function automatic logic [17:0] beat(input logic [7:0] m, input logic [2:0] s,
                                        input logic [3:0] l, input logic last,
                                        input logic empty);
      return {1'b1, m, s, l, last, empty};
   endfunction

   // Waits (bounded) for input_ready, then presents the word for one edge.
   task automatic offer(input bit sel, input logic [7:0] d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (sel ? b.input_ready : a.input_ready) ok = 1'b1;
      end
      if (ok) begin
         if (sel) begin b.input_valid = 1'b1; b.input_data = d; end
         else     begin a.input_valid = 1'b1; a.input_data = d; end
         @(negedge clock);
         a.input_valid = 1'b0;
         b.input_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      tests_run++;
      if (obs(0) !== 18'h0 || a.input_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got %h ready %b, expected 00000 ready 0", obs(0), a.input_ready);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      tests_run++;
      if (a.input_ready !== 1'b1 || a.output_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_ready: got ready %b valid %b, expected 1 0", a.input_ready, a.output_valid);
      end
   endtask

   task automatic test_basic();
      logic [17:0] e [2];
      bit ok;
      e[0] = beat(8'h1C, 3'd2, 4'd3, 1'b0, 1'b0);
      e[1] = beat(8'h40, 3'd6, 4'd1, 1'b1, 1'b0);
      offer(0, 8'h5C, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL basic_accept: timeout waiting for input_ready"); end
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (obs(0) !== e[i]) begin
            tests_failed++;
            $display("FAIL basic_beat%0d: got %h expected %h", i, obs(0), e[i]);
         end
         @(negedge clock);
      end
      tests_run++;
      if (a.output_valid !== 1'b0 || a.input_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_idle: got valid %b ready %b, expected 0 1", a.output_valid, a.input_ready);
      end
   endtask

   task automatic test_ones_then_alt();
      logic [17:0] e [4];
      bit ok;
      offer(0, 8'hFF, ok);
      tests_run++;
      if (!ok || obs(0) !== beat(8'hFF, 3'd0, 4'd8, 1'b1, 1'b0)) begin
         tests_failed++;
         $display("FAIL ones_beat: got %h expected %h (accepted %b)", obs(0), beat(8'hFF, 3'd0, 4'd8, 1'b1, 1'b0), ok);
      end
      @(negedge clock);
      tests_run++;
      if (a.output_valid !== 1'b0 || a.input_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL ones_idle: got valid %b ready %b, expected 0 1", a.output_valid, a.input_ready);
      end
      e[0] = beat(8'h02, 3'd1, 4'd1, 1'b0, 1'b0);
      e[1] = beat(8'h08, 3'd3, 4'd1, 1'b0, 1'b0);
      e[2] = beat(8'h20, 3'd5, 4'd1, 1'b0, 1'b0);
      e[3] = beat(8'h80, 3'd7, 4'd1, 1'b1, 1'b0);
      offer(0, 8'hAA, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL alt_accept: timeout waiting for input_ready"); end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs(0) !== e[i]) begin
            tests_failed++;
            $display("FAIL alt_beat%0d: got %h expected %h", i, obs(0), e[i]);
         end
         @(negedge clock);
      end
      tests_run++;
      if (a.output_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL alt_idle: got valid %b expected 0", a.output_valid);
      end
   endtask

   task automatic test_empty();
      bit ok;
      offer(0, 8'h00, ok);
      tests_run++;
      if (!ok || obs(0) !== beat(8'h00, 3'd0, 4'd0, 1'b1, 1'b1)) begin
         tests_failed++;
         $display("FAIL empty_beat: got %h expected %h (accepted %b)", obs(0), beat(8'h00, 3'd0, 4'd0, 1'b1, 1'b1), ok);
      end
      @(negedge clock);
      tests_run++;
      if (a.output_valid !== 1'b0 || a.input_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL empty_idle: got valid %b ready %b, expected 0 1", a.output_valid, a.input_ready);
      end
   endtask

   task automatic test_polarity();
      bit ok;
      offer(1, 8'hF0, ok);
      tests_run++;
      if (!ok || obs(1) !== beat(8'h0F, 3'd0, 4'd4, 1'b1, 1'b0)) begin
         tests_failed++;
         $display("FAIL polarity_beat: got %h expected %h (accepted %b)", obs(1), beat(8'h0F, 3'd0, 4'd4, 1'b1, 1'b0), ok);
      end
      @(negedge clock);
      tests_run++;
      if (b.output_valid !== 1'b0 || b.input_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL polarity_idle: got valid %b ready %b, expected 0 1", b.output_valid, b.input_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] e1, e2;
      bit ok;
      e1 = beat(8'h1C, 3'd2, 4'd3, 1'b0, 1'b0);
      e2 = beat(8'h40, 3'd6, 4'd1, 1'b1, 1'b0);
      a.output_ready = 1'b0;
      offer(0, 8'h5C, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL bp_accept: timeout waiting for input_ready"); end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (obs(0) !== e1 || a.input_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: got %h ready %b, expected %h ready 0", i, obs(0), a.input_ready, e1);
         end
         @(negedge clock);
      end
      a.output_ready = 1'b1;
      @(negedge clock);
      tests_run++;
      if (obs(0) !== e2) begin
         tests_failed++;
         $display("FAIL bp_beat2: got %h expected %h", obs(0), e2);
      end
      @(negedge clock);
      tests_run++;
      if (a.output_valid !== 1'b0 || a.input_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_idle: got valid %b ready %b, expected 0 1", a.output_valid, a.input_ready);
      end
   endtask

   // input_valid held high across EMIT: the word is re-captured only after
   // the single idle cycle that follows the last beat.
   task automatic test_back_to_back();
      logic [17:0] e [2];
      bit ok;
      e[0] = beat(8'h1C, 3'd2, 4'd3, 1'b0, 1'b0);
      e[1] = beat(8'h40, 3'd6, 4'd1, 1'b1, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (a.input_ready) ok = 1'b1;
      end
      a.input_valid = 1'b1;
      a.input_data  = 8'h5C;
      @(negedge clock);
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs(0) !== e[i] || a.input_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_word%0d_beat%0d: got %h ready %b, expected %h ready 0", w, i, obs(0), a.input_ready, e[i]);
            end
            if (w == 1) a.input_valid = 1'b0;
            @(negedge clock);
         end
         tests_run++;
         if (a.output_valid !== 1'b0 || a.input_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d: got valid %b ready %b, expected 0 1", w, a.output_valid, a.input_ready);
         end
         if (w == 0) @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      offer(0, 8'h81, ok);
      tests_run++;
      if (!ok || obs(0) !== beat(8'h01, 3'd0, 4'd1, 1'b0, 1'b0)) begin
         tests_failed++;
         $display("FAIL rst_mid_beat1: got %h expected %h (accepted %b)", obs(0), beat(8'h01, 3'd0, 4'd1, 1'b0, 1'b0), ok);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if (obs(0) !== 18'h0 || a.input_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_clear: got %h ready %b, expected 00000 ready 0", obs(0), a.input_ready);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      tests_run++;
      if (a.input_ready !== 1'b1 || a.output_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_release: got ready %b valid %b, expected 1 0", a.input_ready, a.output_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         tests_run++;
         if (a.output_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_stale%0d: got valid %b mask %h, expected valid 0", i, a.output_valid, a.output_mask);
         end
      end
   endtask

   initial begin
      clock          = 1'b0;
      reset_n        = 1'b0;
      tests_run      = 0;
      tests_failed   = 0;
      a.input_valid  = 1'b0;
      a.input_data   = '0;
      a.output_ready = 1'b1;
      b.input_valid  = 1'b0;
      b.input_data   = '0;
      b.output_ready = 1'b1;
      test_reset();
      test_basic();
      test_ones_then_alt();
      test_empty();
      test_polarity();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
